data_in_64_to_8: RTL and testbench

//  Transmit-side counterpart of the 8-to-64 byte collector: splits one 64-bit word into eight bytes
//  and hands them, one at a time, to the byte-serial (UART) transmitter.

---
 rtl/data_in_64_to_8.sv | 143 ++++++++++++++
 tb/tb_data_in_64_to_8.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_in_64_to_8.sv
// Splits a captured 64-bit word into eight bytes and feeds them one at a time to a
// UART transmitter, pacing each byte on the transmitter's done pulse.
module data_in_64_to_8 #(
    parameter int MSB_FIRST = 1,
    parameter int BYTE_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_64,
    input  logic        data_in_enable,
    input  logic        tx_done,
    output logic [7:0]  data_8,
    output logic        tx_start,
    output logic        data_in_busy,
    output logic        data_in_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        DONE
    } state_t;

    localparam int GW = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

    state_t         state_q, state_d;
    logic [2:0]     count_q, count_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [63:0]    shadow_q, shadow_d;
    logic           en_q;
    logic [7:0]     data_8_q, data_8_d;
    logic           tx_start_q, tx_start_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load;
    logic           issue;
    logic [7:0]     byte_lane [8];

    // byte_lane[k] is the k-th byte on the wire, whichever end goes first
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            if (MSB_FIRST != 0) begin : g_msb
                assign byte_lane[gi] = shadow_q[63-8*gi -: 8];
            end else begin : g_lsb
                assign byte_lane[gi] = shadow_q[8*gi +: 8];
            end
        end
    endgenerate

    assign load = data_in_enable & ~en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            gap_q      <= '0;
            shadow_q   <= 64'd0;
            en_q       <= 1'b0;
            data_8_q   <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            shadow_q   <= shadow_d;
            en_q       <= data_in_enable;
            data_8_q   <= data_8_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        gap_d      = gap_q;
        shadow_d   = shadow_q;
        data_8_d   = data_8_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shadow_d = data_64;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: issue = 1'b1;
            WAIT: begin
                // An ack arriving while tx_start is still high belongs to no byte yet
                if (tx_done && !tx_start_q) begin
                    if (count_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 3'd1;
                        if (BYTE_GAP == 0) begin
                            issue = 1'b1;
                        end else begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    issue = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                count_d = 3'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            tx_start_d = 1'b1;
            data_8_d   = byte_lane[count_d];
            state_d    = WAIT;
        end
    end

    assign data_8       = data_8_q;
    assign tx_start     = tx_start_q;
    assign data_in_busy = busy_q;
    assign data_in_done = done_q;

endmodule

// File: tb/tb_data_in_64_to_8.sv
// Scoreboard bench: two instances (default MSB-first with gap 2, and LSB-first with no gap),
// each driven by a small UART TX responder.
module tb_data_in_64_to_8;

    localparam int ACK_DLY_A = 10;
    localparam int ACK_DLY_B = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] data_64_a = 64'd0;
    logic        en_a      = 1'b0;
    logic        tx_done_a = 1'b0;
    logic [7:0]  data_8_a;
    logic        tx_start_a, busy_a, done_a;

    logic [63:0] data_64_b = 64'd0;
    logic        en_b      = 1'b0;
    logic        tx_done_b = 1'b0;
    logic [7:0]  data_8_b;
    logic        tx_start_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];
    logic [7:0] exp_byte_a, exp_byte_b;
    int starts_a = 0, dones_a = 0, starts_b = 0, dones_b = 0;

    logic auto_ack = 1'b1;
    logic spur_a   = 1'b0;

    always #5 clk = ~clk;

    data_in_64_to_8 u_dut_a (
        .clk(clk), .rst(rst), .data_64(data_64_a), .data_in_enable(en_a), .tx_done(tx_done_a),
        .data_8(data_8_a), .tx_start(tx_start_a), .data_in_busy(busy_a), .data_in_done(done_a)
    );

    data_in_64_to_8 #(.MSB_FIRST(0), .BYTE_GAP(0)) u_dut_b (
        .clk(clk), .rst(rst), .data_64(data_64_b), .data_in_enable(en_b), .tx_done(tx_done_b),
        .data_8(data_8_b), .tx_start(tx_start_b), .data_in_busy(busy_b), .data_in_done(done_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Responder A: acks ACK_DLY_A cycles after each start, holds the ack while auto_ack is low
    logic pend_a = 1'b0, fire_a = 1'b0, watch_a = 1'b0;
    int   cnt_a = 0, since_a = 0, acks_a = 0;
    always @(negedge clk) begin
        fire_a = 1'b0;
        if (rst) begin
            pend_a = 1'b0; cnt_a = 0; watch_a = 1'b0; acks_a = 0;
        end else begin
            if (watch_a) since_a++;
            if (tx_start_a) begin
                if (watch_a) begin
                    check("gap2_spacing_a", 64'(since_a), 64'd3);
                    watch_a = 1'b0;
                end
                pend_a = 1'b1;
                cnt_a  = ACK_DLY_A;
            end else if (pend_a) begin
                if (cnt_a > 0) cnt_a--;
                if (cnt_a == 0 && auto_ack) begin
                    fire_a = 1'b1;
                    pend_a = 1'b0;
                    acks_a++;
                    if (acks_a < 8) begin
                        watch_a = 1'b1;
                        since_a = 0;
                    end else begin
                        acks_a = 0;
                    end
                end
            end
        end
        tx_done_a = fire_a | spur_a;
    end

    // Responder B: fixed short ack delay; with no gap the next start must follow the ack at once
    logic pend_b = 1'b0, watch_b = 1'b0;
    int   cnt_b = 0, since_b = 0, acks_b = 0;
    always @(negedge clk) begin
        tx_done_b = 1'b0;
        if (rst) begin
            pend_b = 1'b0; cnt_b = 0; watch_b = 1'b0; acks_b = 0;
        end else begin
            if (watch_b) since_b++;
            if (tx_start_b) begin
                if (watch_b) begin
                    check("gap0_spacing_b", 64'(since_b), 64'd1);
                    watch_b = 1'b0;
                end
                pend_b = 1'b1;
                cnt_b  = ACK_DLY_B;
            end else if (pend_b) begin
                if (cnt_b > 0) cnt_b--;
                if (cnt_b == 0) begin
                    tx_done_b = 1'b1;
                    pend_b    = 1'b0;
                    acks_b++;
                    if (acks_b < 8) begin
                        watch_b = 1'b1;
                        since_b = 0;
                    end else begin
                        acks_b = 0;
                    end
                end
            end
        end
    end

    // Monitors: pop one expected byte per tx_start
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start_a) begin
                starts_a++;
                check("sb_has_entry_a", 64'(exp_q_a.size() != 0), 64'd1);
                if (exp_q_a.size() != 0) begin
                    exp_byte_a = exp_q_a.pop_front();
                    check("byte_a", 64'(data_8_a), 64'(exp_byte_a));
                end
            end
            if (done_a) dones_a++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start_b) begin
                starts_b++;
                check("sb_has_entry_b", 64'(exp_q_b.size() != 0), 64'd1);
                if (exp_q_b.size() != 0) begin
                    exp_byte_b = exp_q_b.pop_front();
                    check("byte_b", 64'(data_8_b), 64'(exp_byte_b));
                end
            end
            if (done_b) dones_b++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // seq holds the expected wire order, first byte in bits 63:56
    task automatic push_a(input logic [63:0] seq);
        for (int k = 0; k < 8; k++) exp_q_a.push_back(seq[63-8*k -: 8]);
    endtask

    task automatic push_b(input logic [63:0] seq);
        for (int k = 0; k < 8; k++) exp_q_b.push_back(seq[63-8*k -: 8]);
    endtask

    task automatic load_a(input logic [63:0] word);
        data_64_a = word;
        en_a      = 1'b1;
        tick(1);
        en_a      = 1'b0;
    endtask

    task automatic wait_done_a(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
        check({name, "_busy_low"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        int  base_s, base_d;
        logic seen;
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   base_s, base_d;
        logic seen;

        tick(3);
        check("rst_data_8",   64'(data_8_a),   64'h00);
        check("rst_tx_start", 64'(tx_start_a), 64'd0);
        check("rst_busy",     64'(busy_a),     64'd0);
        check("rst_done",     64'(done_a),     64'd0);
        check("rst_data_8_b", 64'(data_8_b),   64'h00);
        rst = 1'b0;
        tick(2);

        // T1: single transfer, latency of first start, input change after load ignored
        base_s = starts_a; base_d = dones_a;
        push_a(64'hd7a701a0c40427cb);
        load_a(64'hd7a701a0c40427cb);
        data_64_a = 64'hffffffffffffffff;
        check("t1_busy_at_load",  64'(busy_a),     64'd1);
        check("t1_no_start_yet",  64'(tx_start_a), 64'd0);
        tick(1);
        check("t1_first_start",   64'(tx_start_a), 64'd1);
        wait_done_a("t1_done", 400);

        // T2: reload on the cycle after done
        push_a(64'h464d749afa037423);
        load_a(64'h464d749afa037423);
        check("t2_busy_reload", 64'(busy_a), 64'd1);
        check("t1_starts", 64'(starts_a - base_s), 64'd8);
        wait_done_a("t2_done", 400);
        tick(3);
        check("t12_starts", 64'(starts_a - base_s), 64'd16);
        check("t12_dones",  64'(dones_a - base_d),  64'd2);
        check("t12_sb_empty", 64'(exp_q_a.size()), 64'd0);

        // T3: enable held two cycles, then an extra edge while busy
        base_s = starts_a; base_d = dones_a;
        push_a(64'h1122334455667788);
        data_64_a = 64'h1122334455667788;
        en_a = 1'b1;
        tick(2);
        en_a = 1'b0;
        tick(15);
        en_a = 1'b1;
        tick(1);
        en_a = 1'b0;
        wait_done_a("t3_done", 400);
        tick(40);
        check("t3_starts", 64'(starts_a - base_s), 64'd8);
        check("t3_dones",  64'(dones_a - base_d),  64'd1);
        check("t3_idle",   64'(busy_a),            64'd0);

        // T4: spurious ack in idle and on the tx_start cycle
        base_s = starts_a; base_d = dones_a;
        check("t4_data_8_kept", 64'(data_8_a), 64'h88);
        spur_a = 1'b1;
        tick(1);
        spur_a = 1'b0;
        tick(3);
        check("t4_idle_busy",   64'(busy_a),            64'd0);
        check("t4_idle_starts", 64'(starts_a - base_s), 64'd0);
        auto_ack = 1'b0;
        push_a(64'hcafef00d12345678);
        load_a(64'hcafef00d12345678);
        tick(1);
        check("t4_start_cycle", 64'(tx_start_a), 64'd1);
        spur_a = 1'b1;
        tick(1);
        spur_a = 1'b0;
        tick(20);
        check("t4_stall_busy",   64'(busy_a),            64'd1);
        check("t4_stall_starts", 64'(starts_a - base_s), 64'd1);
        check("t4_stall_byte",   64'(data_8_a),          64'hca);
        auto_ack = 1'b1;
        wait_done_a("t4_done", 400);
        tick(3);
        check("t4_starts", 64'(starts_a - base_s), 64'd8);
        check("t4_dones",  64'(dones_a - base_d),  64'd1);

        // T5: reset while waiting on byte 3
        base_s = starts_a; base_d = dones_a;
        push_a(64'h0f1e2d3c4b5a6978);
        load_a(64'h0f1e2d3c4b5a6978);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (starts_a - base_s >= 4) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_reach_byte3", 64'(seen), 64'd1);
        tick(2);
        rst = 1'b1;
        #1;
        check("t5_rst_data_8",   64'(data_8_a),   64'h00);
        check("t5_rst_tx_start", 64'(tx_start_a), 64'd0);
        check("t5_rst_busy",     64'(busy_a),     64'd0);
        check("t5_rst_done",     64'(done_a),     64'd0);
        exp_q_a.delete();
        tick(1);
        rst = 1'b0;
        tick(30);
        check("t5_no_more_starts", 64'(starts_a - base_s), 64'd4);
        check("t5_no_done",        64'(dones_a - base_d),  64'd0);
        base_s = starts_a;
        push_a(64'h8899aabbccddeeff);
        load_a(64'h8899aabbccddeeff);
        wait_done_a("t5_restart_done", 400);
        tick(3);
        check("t5_restart_starts", 64'(starts_a - base_s), 64'd8);

        // T6: LSB first, no gap
        push_b(64'hefcdab8967452301);
        data_64_b = 64'h0123456789abcdef;
        en_b = 1'b1;
        tick(1);
        en_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (done_b) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_done", 64'(seen), 64'd1);
        tick(3);
        check("t6_starts",   64'(starts_b),       64'd8);
        check("t6_dones",    64'(dones_b),        64'd1);
        check("t6_sb_empty", 64'(exp_q_b.size()), 64'd0);
        check("t6_busy_low", 64'(busy_b),         64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
